// File: rtl/sha1_msg_padder.sv
// SHA-1 front end: packs a byte stream into padded 512-bit big-endian blocks for the hash core.
// blk_start 1 cycle after a full block (3 after the last byte); msg_ready low outside FILL, bytes held off until blk_done.
module sha1_msg_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   msg_byte,
    input  logic         msg_valid,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic         blk_start,
    output logic [511:0] blk_data,
    output logic         blk_final,
    input  logic         blk_done,
    output logic         msg_done
);

    typedef enum logic [2:0] {FILL, MARK, LEN, SEND, WAIT} state_t;

    state_t       state;
    state_t       ret;
    logic [511:0] blk_buf;
    logic [6:0]   ptr;
    logic [31:0]  cnt;
    logic         fin;
    logic [8:0]   hi;
    logic         hs;

    // byte 0 lives in bits [511:504]
    assign hi = 9'd511 - {ptr[5:0], 3'b000};
    assign hs = msg_valid & msg_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            ret       <= FILL;
            blk_buf   <= '0;
            ptr       <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
            msg_ready <= 1'b0;
            blk_start <= 1'b0;
            blk_data  <= '0;
            blk_final <= 1'b0;
            msg_done  <= 1'b0;
        end else begin
            blk_start <= 1'b0;
            msg_done  <= 1'b0;
            case (state)
                FILL: begin
                    msg_ready <= 1'b1;
                    if (hs) begin
                        blk_buf[hi -: 8] <= msg_byte;
                        ptr              <= ptr + 7'd1;
                        cnt              <= cnt + 32'd1;
                        if (msg_last) begin
                            state     <= MARK;
                            msg_ready <= 1'b0;
                        end else if (ptr == 7'd63) begin
                            state     <= SEND;
                            ret       <= FILL;
                            msg_ready <= 1'b0;
                            blk_start <= 1'b1;
                            blk_data  <= {blk_buf[511:8], msg_byte};
                            blk_final <= 1'b0;
                        end
                    end
                end
                MARK: begin
                    if (ptr[6]) begin
                        // full block already: ship it and place the marker in a fresh block
                        state     <= SEND;
                        ret       <= MARK;
                        blk_start <= 1'b1;
                        blk_data  <= blk_buf;
                        blk_final <= 1'b0;
                    end else begin
                        blk_buf[hi -: 8] <= 8'h80;
                        ptr              <= ptr + 7'd1;
                        state            <= LEN;
                    end
                end
                LEN: begin
                    state     <= SEND;
                    blk_start <= 1'b1;
                    if (ptr <= 7'd56) begin
                        blk_buf[63:0] <= {29'b0, cnt, 3'b000};
                        fin           <= 1'b1;
                        blk_data      <= {blk_buf[511:64], 29'b0, cnt, 3'b000};
                        blk_final     <= 1'b1;
                    end else begin
                        // no room for the length field; it goes into a spill block
                        ret       <= LEN;
                        blk_data  <= blk_buf;
                        blk_final <= 1'b0;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (blk_done) begin
                        blk_buf <= '0;
                        ptr     <= '0;
                        if (fin) begin
                            msg_done  <= 1'b1;
                            cnt       <= '0;
                            fin       <= 1'b0;
                            state     <= FILL;
                            msg_ready <= 1'b1;
                        end else begin
                            state     <= ret;
                            msg_ready <= (ret == FILL);
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    msg_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: drives byte streams, emulates the hash core's done, checks blocks and timing.
module tb_sha1_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   msg_byte;
    logic         msg_valid;
    logic         msg_last;
    logic         msg_ready;
    logic         blk_start;
    logic [511:0] blk_data;
    logic         blk_final;
    logic         blk_done;
    logic         msg_done;

    sha1_msg_padder dut (
        .clk       (clk),
        .reset     (reset),
        .msg_byte  (msg_byte),
        .msg_valid (msg_valid),
        .msg_last  (msg_last),
        .msg_ready (msg_ready),
        .blk_start (blk_start),
        .blk_data  (blk_data),
        .blk_final (blk_final),
        .blk_done  (blk_done),
        .msg_done  (msg_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   msg     [0:255];
    logic [511:0] cap_dat [0:3];
    logic         cap_fin [0:3];
    int           cap_cyc [0:3];
    int           hs_cyc  [0:255];
    int           nblk, ndone, mdone_cyc, done_cyc, viol, stale;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack(input int start, input int n);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[511-8*j -: 8] = msg[start+j];
        return r;
    endfunction

    function automatic logic [511:0] at(input int pos, input logic [7:0] v);
        logic [511:0] r;
        r = '0;
        r[511-8*pos -: 8] = v;
        return r;
    endfunction

    task automatic fill_pat(input int n, input int mul);
        for (int j = 0; j < n; j++) msg[j] = 8'((j * mul + 3) & 255);
    endtask

    task automatic fill_55();
        for (int j = 0; j < 55; j++) msg[j] = 8'(8'h61 + (j % 26));
        msg[0]  = 8'h39; msg[1]  = 8'h4e; msg[2] = 8'h78; msg[3] = 8'h56;
        msg[52] = 8'h44; msg[53] = 8'h4d; msg[54] = 8'h24;
    endtask

    // Feeds msg[0..n-1] and answers each blk_start with blk_done dly cycles later.
    // With abort set it stops 5 cycles into the first block's wait without answering.
    task automatic run_msg(input int n, input int dly, input bit abort);
        int i, cyc, cnt_dn;
        bit busy;
        i = 0; cyc = 0; cnt_dn = -1; busy = 0;
        nblk = 0; ndone = 0; mdone_cyc = -1; done_cyc = -10; viol = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            cyc++;
            if (blk_start) begin
                if (nblk < 4) begin
                    cap_dat[nblk] = blk_data;
                    cap_fin[nblk] = blk_final;
                    cap_cyc[nblk] = cyc;
                end
                nblk++;
                busy   = 1;
                cnt_dn = dly;
            end
            if (msg_done) begin
                ndone++;
                mdone_cyc = cyc;
            end
            if (busy && msg_ready) viol++;
            if (cyc == done_cyc + 1 && (i < n || ndone > 0) && !msg_ready) viol++;
            blk_done = 1'b0;
            if (cnt_dn == 0) begin
                blk_done = 1'b1;
                done_cyc = cyc;
                busy     = 0;
                cnt_dn   = -1;
            end else if (cnt_dn > 0) begin
                cnt_dn--;
            end
            if (abort && nblk > 0 && cyc >= cap_cyc[0] + 5) break;
            msg_valid = (i < n);
            msg_byte  = (i < n) ? msg[i] : 8'h00;
            msg_last  = (i == n - 1);
            if (i < n && msg_ready) begin
                hs_cyc[i] = cyc;
                i++;
            end
            if (ndone > 0) break;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        if (abort == 0) begin
            @(negedge clk);
            blk_done = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        msg_byte  = 8'h00;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        blk_done  = 1'b0;

        // reset state
        #12;
        chk("rst_blk_start", 512'(blk_start), 512'd0);
        chk("rst_blk_data", blk_data, 512'd0);
        chk("rst_blk_final", 512'(blk_final), 512'd0);
        chk("rst_msg_done", 512'(msg_done), 512'd0);
        chk("rst_msg_ready", 512'(msg_ready), 512'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("ready_before_edge", 512'(msg_ready), 512'd0);
        @(negedge clk);
        chk("ready_after_reset", 512'(msg_ready), 512'd1);

        // 55-byte message: single block
        fill_55();
        run_msg(55, 3, 0);
        chk_i("m55_nblk", nblk, 1);
        chk("m55_blk", cap_dat[0], pack(0, 55) | at(55, 8'h80) | 512'h1b8);
        chk("m55_top", 512'(cap_dat[0][511:480]), 512'h394e7856);
        chk("m55_final", 512'(cap_fin[0]), 512'd1);
        chk_i("m55_start_lat", cap_cyc[0] - hs_cyc[54], 3);
        chk_i("m55_done", ndone, 1);
        chk_i("m55_ready", viol, 0);

        // 1-byte message
        msg[0] = 8'h61;
        run_msg(1, 3, 0);
        chk_i("m1_nblk", nblk, 1);
        chk("m1_blk", cap_dat[0], {16'h6180, 432'h0, 64'h8});
        chk("m1_final", 512'(cap_fin[0]), 512'd1);
        chk_i("m1_start_lat", cap_cyc[0] - hs_cyc[0], 3);
        chk_i("m1_done_lat", mdone_cyc - done_cyc, 1);
        chk_i("m1_done", ndone, 1);

        // 56-byte message: length spills into a second block
        fill_pat(56, 7);
        run_msg(56, 2, 0);
        chk_i("m56_nblk", nblk, 2);
        chk("m56_blk0", cap_dat[0], pack(0, 56) | at(56, 8'h80));
        chk("m56_fin0", 512'(cap_fin[0]), 512'd0);
        chk("m56_blk1", cap_dat[1], 512'h1c0);
        chk("m56_fin1", 512'(cap_fin[1]), 512'd1);
        chk_i("m56_done", ndone, 1);

        // 64-byte message: marker goes into a second block
        fill_pat(64, 13);
        run_msg(64, 4, 0);
        chk_i("m64_nblk", nblk, 2);
        chk("m64_blk0", cap_dat[0], pack(0, 64));
        chk("m64_fin0", 512'(cap_fin[0]), 512'd0);
        chk("m64_blk1", cap_dat[1], {8'h80, 440'h0, 64'h200});
        chk("m64_fin1", 512'(cap_fin[1]), 512'd1);
        chk_i("m64_done", ndone, 1);

        // 130 bytes, valid held high, slow core
        fill_pat(130, 5);
        run_msg(130, 50, 0);
        chk_i("bp_nblk", nblk, 3);
        chk("bp_blk0", cap_dat[0], pack(0, 64));
        chk("bp_blk1", cap_dat[1], pack(64, 64));
        chk("bp_blk2", cap_dat[2], pack(128, 2) | at(2, 8'h80) | 512'h410);
        chk("bp_fin", {cap_fin[0], cap_fin[1], cap_fin[2]}, 3'b001);
        chk_i("bp_start_lat0", cap_cyc[0] - hs_cyc[63], 1);
        chk_i("bp_start_lat1", cap_cyc[1] - hs_cyc[127], 1);
        chk_i("bp_ready", viol, 0);
        chk_i("bp_done", ndone, 1);

        // reset in WAIT of the first block of a 100-byte message
        fill_pat(100, 11);
        run_msg(100, 1000, 1);
        chk_i("ab_nblk", nblk, 1);
        chk("ab_blk0", cap_dat[0], pack(0, 64));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ab_blk_start", 512'(blk_start), 512'd0);
        chk("ab_blk_data", blk_data, 512'd0);
        chk("ab_blk_final", 512'(blk_final), 512'd0);
        chk("ab_msg_done", 512'(msg_done), 512'd0);
        chk("ab_msg_ready", 512'(msg_ready), 512'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ab_ready_back", 512'(msg_ready), 512'd1);
        blk_done = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            blk_done = 1'b0;
            if (msg_done || blk_start || !msg_ready) stale++;
        end
        chk_i("ab_stale_done", stale, 0);

        fill_55();
        run_msg(55, 3, 0);
        chk_i("ab55_nblk", nblk, 1);
        chk("ab55_blk", cap_dat[0], pack(0, 55) | at(55, 8'h80) | 512'h1b8);
        chk("ab55_final", 512'(cap_fin[0]), 512'd1);
        chk_i("ab55_done", ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
